// File: rtl/ula_seq_if.sv
// ula_seq_if: handshake and operand/result bus between a requester and ula_seq.
//   start/op/a/b   requester -> ALU  (request and unsigned operands)
//   busy/done      ALU -> requester  (MUL in progress / one-cycle completion pulse)
//   result/cout    ALU -> requester  (2N-bit result, carry or borrow)
//   eq/gt/lt/zero  ALU -> requester  (compare flags of captured operands, result==0)
interface ula_seq_if #(
    parameter int unsigned N = 8
);
    logic             start;
    logic [1:0]       op;
    logic [N-1:0]     a;
    logic [N-1:0]     b;
    logic             busy;
    logic             done;
    logic [2*N-1:0]   result;
    logic             cout;
    logic             eq;
    logic             gt;
    logic             lt;
    logic             zero;

    modport master (
        output start, op, a, b,
        input  busy, done, result, cout, eq, gt, lt, zero
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, result, cout, eq, gt, lt, zero
    );
endinterface

// File: rtl/ula_seq.sv
// ula_seq: registered N-bit ALU (ADD, SUB, CMP in one cycle; MUL by iterative
// shift-add over N cycles) with start/busy/done handshake.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    ula_seq_if slave port (request, operands, registered result and flags)
module ula_seq #(
    parameter int unsigned N = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    ula_seq_if.slave   bus
);
    localparam int unsigned RW = 2 * N;
    localparam int unsigned CW = $clog2(N);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_CMP = 2'b10;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

    state_t          r_state;
    logic            r_busy;
    logic            r_done;
    logic [RW-1:0]   r_result;
    logic            r_cout;
    logic            r_eq;
    logic            r_gt;
    logic            r_lt;
    logic            r_zero;
    logic [CW-1:0]   r_cnt;
    logic [RW-1:0]   r_acc;
    logic [RW-1:0]   r_mcand;
    logic [N-1:0]    r_b;

    state_t          w_state_nxt;
    logic            w_busy_nxt;
    logic            w_done_nxt;
    logic [RW-1:0]   w_result_nxt;
    logic            w_cout_nxt;
    logic            w_eq_nxt;
    logic            w_gt_nxt;
    logic            w_lt_nxt;
    logic            w_zero_nxt;
    logic [CW-1:0]   w_cnt_nxt;
    logic [RW-1:0]   w_acc_nxt;
    logic [RW-1:0]   w_mcand_nxt;
    logic [N-1:0]    w_b_nxt;

    logic [N:0]      w_sum;
    logic [N:0]      w_diff;
    logic [RW-1:0]   w_acc_sum;
    logic            w_last;

    // Bit N of the widened difference is the borrow, i.e. a < b.
    assign w_sum     = {1'b0, bus.a} + {1'b0, bus.b};
    assign w_diff    = {1'b0, bus.a} - {1'b0, bus.b};
    assign w_acc_sum = r_acc + (r_b[r_cnt] ? r_mcand : '0);
    assign w_last    = (r_cnt == CW'(N - 1));

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
            r_cout   <= 1'b0;
            r_eq     <= 1'b0;
            r_gt     <= 1'b0;
            r_lt     <= 1'b0;
            r_zero   <= 1'b1;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_b      <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
            r_result <= w_result_nxt;
            r_cout   <= w_cout_nxt;
            r_eq     <= w_eq_nxt;
            r_gt     <= w_gt_nxt;
            r_lt     <= w_lt_nxt;
            r_zero   <= w_zero_nxt;
            r_cnt    <= w_cnt_nxt;
            r_acc    <= w_acc_nxt;
            r_mcand  <= w_mcand_nxt;
            r_b      <= w_b_nxt;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        w_state_nxt  = r_state;
        w_busy_nxt   = r_busy;
        w_done_nxt   = 1'b0;
        w_result_nxt = r_result;
        w_cout_nxt   = r_cout;
        w_eq_nxt     = r_eq;
        w_gt_nxt     = r_gt;
        w_lt_nxt     = r_lt;
        w_zero_nxt   = r_zero;
        w_cnt_nxt    = r_cnt;
        w_acc_nxt    = r_acc;
        w_mcand_nxt  = r_mcand;
        w_b_nxt      = r_b;

        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_b_nxt    = bus.b;
                    w_eq_nxt   = (bus.a == bus.b);
                    w_gt_nxt   = (bus.a >  bus.b);
                    w_lt_nxt   = (bus.a <  bus.b);
                    w_done_nxt = 1'b1;
                    case (bus.op)
                        OP_ADD: begin
                            w_result_nxt = RW'(w_sum);
                            w_cout_nxt   = w_sum[N];
                            w_zero_nxt   = (w_sum == '0);
                        end
                        OP_SUB: begin
                            w_result_nxt = RW'(w_diff[N-1:0]);
                            w_cout_nxt   = w_diff[N];
                            w_zero_nxt   = (w_diff[N-1:0] == '0);
                        end
                        OP_CMP: begin
                            w_result_nxt = '0;
                            w_cout_nxt   = 1'b0;
                            w_zero_nxt   = 1'b1;
                        end
                        default: begin
                            // MUL: multiplicand is the zero-extended captured a.
                            w_done_nxt  = 1'b0;
                            w_state_nxt = S_MUL;
                            w_busy_nxt  = 1'b1;
                            w_cnt_nxt   = '0;
                            w_acc_nxt   = '0;
                            w_mcand_nxt = RW'(bus.a);
                        end
                    endcase
                end
            end
            S_MUL: begin
                // One partial product per cycle, selected by captured b bit cnt.
                w_acc_nxt   = w_acc_sum;
                w_mcand_nxt = r_mcand << 1;
                w_cnt_nxt   = r_cnt + CW'(1);
                if (w_last) begin
                    w_result_nxt = w_acc_sum;
                    w_cout_nxt   = 1'b0;
                    w_zero_nxt   = (w_acc_sum == '0);
                    w_done_nxt   = 1'b1;
                    w_busy_nxt   = 1'b0;
                    w_state_nxt  = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
    assign bus.result = r_result;
    assign bus.cout   = r_cout;
    assign bus.eq     = r_eq;
    assign bus.gt     = r_gt;
    assign bus.lt     = r_lt;
    assign bus.zero   = r_zero;
endmodule

// File: tb/tb_ula_seq.sv
// tb_ula_seq: directed self-checking bench for ula_seq at N=8 and N=16.
// Inputs are driven and outputs sampled on the falling edge; the sample at
// falling edge i after a request reflects rising edge k+i-1, so an ALU op
// shows done at i=1 and an N-bit MUL shows done at i=N+1.
module tb_ula_seq;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    ula_seq_if #(.N(8))  if8 ();
    ula_seq_if #(.N(16)) if16 ();

    ula_seq #(.N(8))  u8  (.clk(clk), .rst_n(rst_n), .bus(if8.slave));
    ula_seq #(.N(16)) u16 (.clk(clk), .rst_n(rst_n), .bus(if16.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    // Issue a MUL on the 8-bit unit; lat = falling-edge index of done, -1 if none.
    task automatic mul8(input logic [7:0] a, input logic [7:0] b, output int lat);
        if8.start = 1'b1; if8.op = 2'b11; if8.a = a; if8.b = b;
        lat = -1;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (i == 1) begin
                if8.start = 1'b0; if8.a = 8'h5A; if8.b = 8'hA5;
            end
            if (if8.done === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic mul16(input logic [15:0] a, input logic [15:0] b, output int lat);
        if16.start = 1'b1; if16.op = 2'b11; if16.a = a; if16.b = b;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (i == 1) begin
                if16.start = 1'b0; if16.a = 16'h0F0F; if16.b = 16'hF0F0;
            end
            if (if16.done === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (if8.busy !== 1'b0 || if8.done !== 1'b0) begin bad++; $display("FAIL reset_hs: busy=%b done=%b want 0 0", if8.busy, if8.done); end
        total++; if (if8.result !== 16'h0000 || if8.cout !== 1'b0) begin bad++; $display("FAIL reset_res: result=%h cout=%b want 0000 0", if8.result, if8.cout); end
        total++; if ({if8.eq, if8.gt, if8.lt, if8.zero} !== 4'b0001) begin bad++; $display("FAIL reset_flags: eq/gt/lt/zero=%b want 0001", {if8.eq, if8.gt, if8.lt, if8.zero}); end
        total++; if (if16.result !== 32'h0 || if16.zero !== 1'b1) begin bad++; $display("FAIL reset16: result=%h zero=%b want 0 1", if16.result, if16.zero); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_add();
        if8.start = 1'b1; if8.op = 2'b00; if8.a = 8'd200; if8.b = 8'd100;
        @(negedge clk);
        if8.start = 1'b0;
        total++; if (if8.done !== 1'b1) begin bad++; $display("FAIL add_done: got %b want 1", if8.done); end
        total++; if (if8.result !== 16'h012C || if8.cout !== 1'b1) begin bad++; $display("FAIL add_result: result=%h cout=%b want 012c 1", if8.result, if8.cout); end
        total++; if ({if8.eq, if8.gt, if8.lt, if8.zero} !== 4'b0100) begin bad++; $display("FAIL add_flags: eq/gt/lt/zero=%b want 0100", {if8.eq, if8.gt, if8.lt, if8.zero}); end
        @(negedge clk);
        total++; if (if8.done !== 1'b0 || if8.result !== 16'h012C) begin bad++; $display("FAIL add_after: done=%b result=%h want 0 012c", if8.done, if8.result); end
    endtask

    task automatic test_sub_back_to_back();
        if8.start = 1'b1; if8.op = 2'b01; if8.a = 8'd5; if8.b = 8'd9;
        @(negedge clk);
        total++; if (if8.done !== 1'b1 || if8.result !== 16'h00FC || if8.cout !== 1'b1) begin bad++; $display("FAIL sub1: done=%b result=%h cout=%b want 1 00fc 1", if8.done, if8.result, if8.cout); end
        total++; if ({if8.eq, if8.gt, if8.lt, if8.zero} !== 4'b0010) begin bad++; $display("FAIL sub1_flags: eq/gt/lt/zero=%b want 0010", {if8.eq, if8.gt, if8.lt, if8.zero}); end
        if8.a = 8'd9; if8.b = 8'd9;
        @(negedge clk);
        if8.start = 1'b0;
        total++; if (if8.done !== 1'b1 || if8.result !== 16'h0000 || if8.cout !== 1'b0) begin bad++; $display("FAIL sub2: done=%b result=%h cout=%b want 1 0000 0", if8.done, if8.result, if8.cout); end
        total++; if ({if8.eq, if8.gt, if8.lt, if8.zero} !== 4'b1001) begin bad++; $display("FAIL sub2_flags: eq/gt/lt/zero=%b want 1001", {if8.eq, if8.gt, if8.lt, if8.zero}); end
        @(negedge clk);
        total++; if (if8.done !== 1'b0) begin bad++; $display("FAIL sub_done_drop: got %b want 0", if8.done); end
    endtask

    task automatic test_cmp();
        if8.start = 1'b1; if8.op = 2'b10; if8.a = 8'h80; if8.b = 8'h7F;
        @(negedge clk);
        if8.start = 1'b0;
        total++; if (if8.done !== 1'b1 || if8.result !== 16'h0000 || if8.cout !== 1'b0) begin bad++; $display("FAIL cmp_res: done=%b result=%h cout=%b want 1 0000 0", if8.done, if8.result, if8.cout); end
        total++; if ({if8.eq, if8.gt, if8.lt, if8.zero} !== 4'b0101) begin bad++; $display("FAIL cmp_flags: eq/gt/lt/zero=%b want 0101", {if8.eq, if8.gt, if8.lt, if8.zero}); end
        @(negedge clk);
    endtask

    // MUL 255*255 with an ADD request during busy, then an ADD in the done cycle.
    task automatic test_mul_ignore_start();
        int busy_bad;
        int done_bad;
        busy_bad = 0; done_bad = 0;
        if8.start = 1'b1; if8.op = 2'b11; if8.a = 8'd255; if8.b = 8'd255;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (i == 1) begin if8.start = 1'b0; if8.a = 8'd0; if8.b = 8'd0; end
            if (i == 3) begin if8.start = 1'b1; if8.op = 2'b00; if8.a = 8'd1; if8.b = 8'd1; end
            if (i == 4) if8.start = 1'b0;
            if (if8.busy !== 1'b1) busy_bad++;
            if (if8.done !== 1'b0) done_bad++;
        end
        total++; if (busy_bad != 0) begin bad++; $display("FAIL mul_busy: busy low in %0d of 8 cycles want 0", busy_bad); end
        total++; if (done_bad != 0) begin bad++; $display("FAIL mul_early_done: done high in %0d cycles want 0", done_bad); end
        @(negedge clk);
        total++; if (if8.done !== 1'b1 || if8.busy !== 1'b0) begin bad++; $display("FAIL mul_done: done=%b busy=%b want 1 0", if8.done, if8.busy); end
        total++; if (if8.result !== 16'hFE01 || if8.cout !== 1'b0 || if8.zero !== 1'b0 || if8.eq !== 1'b1) begin bad++; $display("FAIL mul_result: result=%h cout=%b zero=%b eq=%b want fe01 0 0 1", if8.result, if8.cout, if8.zero, if8.eq); end
        if8.start = 1'b1; if8.op = 2'b00; if8.a = 8'd2; if8.b = 8'd3;
        @(negedge clk);
        if8.start = 1'b0;
        total++; if (if8.done !== 1'b1 || if8.result !== 16'h0005) begin bad++; $display("FAIL no_bubble: done=%b result=%h want 1 0005", if8.done, if8.result); end
        @(negedge clk);
    endtask

    task automatic test_mul_random();
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] exp;
        int          lat;
        for (int n = 0; n < 5; n++) begin
            a = 8'($urandom_range(1, 255));
            b = 8'($urandom_range(1, 255));
            exp = 16'(a) * 16'(b);
            mul8(a, b, lat);
            total++; if (lat != 9) begin bad++; $display("FAIL mulr_latency: %0d*%0d done at %0d want 9", a, b, lat); end
            total++; if (if8.result !== exp) begin bad++; $display("FAIL mulr_result: %0d*%0d got %h want %h", a, b, if8.result, exp); end
            @(negedge clk);
        end
    endtask

    task automatic test_mul16();
        int lat;
        mul16(16'hFFFF, 16'hFFFF, lat);
        total++; if (lat != 17) begin bad++; $display("FAIL mul16_latency: done at %0d want 17", lat); end
        total++; if (if16.result !== 32'hFFFE0001 || if16.zero !== 1'b0) begin bad++; $display("FAIL mul16_max: result=%h zero=%b want fffe0001 0", if16.result, if16.zero); end
        @(negedge clk);
        mul16(16'h1234, 16'h0000, lat);
        total++; if (lat != 17) begin bad++; $display("FAIL mul16_b0_latency: done at %0d want 17", lat); end
        total++; if (if16.result !== 32'h0 || if16.zero !== 1'b1 || if16.gt !== 1'b1) begin bad++; $display("FAIL mul16_b0: result=%h zero=%b gt=%b want 0 1 1", if16.result, if16.zero, if16.gt); end
        @(negedge clk);
    endtask

    task automatic test_reset_during_mul();
        int saw_done;
        saw_done = 0;
        if8.start = 1'b1; if8.op = 2'b11; if8.a = 8'd3; if8.b = 8'd7;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            if (i == 1) if8.start = 1'b0;
        end
        total++; if (if8.busy !== 1'b1 || if8.lt !== 1'b1) begin bad++; $display("FAIL rmul_busy: busy=%b lt=%b want 1 1", if8.busy, if8.lt); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (if8.busy !== 1'b0 || if8.done !== 1'b0 || if8.result !== 16'h0 || if8.cout !== 1'b0) begin bad++; $display("FAIL rmul_outputs: busy=%b done=%b result=%h cout=%b want 0 0 0000 0", if8.busy, if8.done, if8.result, if8.cout); end
        total++; if ({if8.eq, if8.gt, if8.lt, if8.zero} !== 4'b0001) begin bad++; $display("FAIL rmul_flags: eq/gt/lt/zero=%b want 0001", {if8.eq, if8.gt, if8.lt, if8.zero}); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (if8.done !== 1'b0 || if8.busy !== 1'b0) saw_done++;
        end
        total++; if (saw_done != 0) begin bad++; $display("FAIL rmul_no_done: activity in %0d cycles want 0", saw_done); end
        if8.start = 1'b1; if8.op = 2'b00; if8.a = 8'd1; if8.b = 8'd2;
        @(negedge clk);
        if8.start = 1'b0;
        total++; if (if8.done !== 1'b1 || if8.result !== 16'h0003 || if8.cout !== 1'b0) begin bad++; $display("FAIL rmul_add: done=%b result=%h cout=%b want 1 0003 0", if8.done, if8.result, if8.cout); end
        @(negedge clk);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        if8.start = 1'b0;  if8.op = 2'b00;  if8.a = '0;  if8.b = '0;
        if16.start = 1'b0; if16.op = 2'b00; if16.a = '0; if16.b = '0;
        @(negedge clk);
        test_reset();
        test_add();
        test_sub_back_to_back();
        test_cmp();
        test_mul_ignore_start();
        test_mul_random();
        test_mul16();
        test_reset_during_mul();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
